// File: rtl/divider_if.sv
// Request/response bundle for the iterative divider: operand handshake,
// flush, and result handshake. Clock and reset stay outside the bundle.
interface divider_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  flush_i;
   logic                  div_signed_i;
   logic [DATA_WIDTH-1:0] X_i;
   logic [DATA_WIDTH-1:0] Y_i;
   logic                  valid_i;
   logic                  ready_o;
   logic                  valid_o;
   logic                  ready_i;
   logic [DATA_WIDTH-1:0] q_o;
   logic [DATA_WIDTH-1:0] r_o;

   // Pipeline side: issues operands, consumes results.
   modport master (
      output flush_i, div_signed_i, X_i, Y_i, valid_i, ready_i,
      input  ready_o, valid_o, q_o, r_o
   );

   // Divider side.
   modport slave (
      input  flush_i, div_signed_i, X_i, Y_i, valid_i, ready_i,
      output ready_o, valid_o, q_o, r_o
   );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring integer divider (DIV.W/MOD.W/DIV.WU/MOD.WU).
// One quotient bit per cycle, MSB first; fixed latency of DATA_WIDTH cycles
// from acceptance to valid result. Signed operands are divided as magnitudes
// and the signs are restored on the final iteration edge.
module divider #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst,
   divider_if.slave  bus
);
   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_rem;     // partial remainder, always < |Y| between iterations
   logic [DW-1:0]   r_dvd;     // dividend bits shift out the top, quotient bits shift in at the bottom
   logic [DW-1:0]   r_dsr;     // |Y|
   logic [DW-1:0]   r_xraw;    // dividend as presented, returned as remainder on divide-by-zero
   logic            r_qneg;
   logic            r_rneg;
   logic            r_div0;
   logic [DW-1:0]   r_q;
   logic [DW-1:0]   r_r;

   logic [DW-1:0]   w_xabs;
   logic [DW-1:0]   w_yabs;
   logic [DW:0]     w_rem_sh;
   logic [DW:0]     w_diff;
   logic            w_ge;
   logic [DW-1:0]   w_rem_nx;
   logic [DW-1:0]   w_dvd_nx;
   logic [DW-1:0]   w_qfix;
   logic [DW-1:0]   w_rfix;

   assign w_xabs = (bus.div_signed_i && bus.X_i[DW-1]) ? -bus.X_i : bus.X_i;
   assign w_yabs = (bus.div_signed_i && bus.Y_i[DW-1]) ? -bus.Y_i : bus.Y_i;

   // The shifted remainder is DW+1 bits wide; since it stays below 2*|Y|,
   // the borrow out of the subtraction alone decides the quotient bit.
   assign w_rem_sh = {r_rem, r_dvd[DW-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dsr};
   assign w_ge     = ~w_diff[DW];
   assign w_rem_nx = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
   assign w_dvd_nx = {r_dvd[DW-2:0], w_ge};

   assign w_qfix = r_div0 ? '1     : (r_qneg ? -w_dvd_nx : w_dvd_nx);
   assign w_rfix = r_div0 ? r_xraw : (r_rneg ? -w_rem_nx : w_rem_nx);

   assign bus.ready_o = (r_state == IDLE);
   assign bus.valid_o = (r_state == DONE);
   assign bus.q_o     = r_q;
   assign bus.r_o     = r_r;

   // Control FSM and datapath: accept, iterate, hold result until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_xraw  <= '0;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_div0  <= 1'b0;
         r_q     <= '0;
         r_r     <= '0;
      end else if (bus.flush_i) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.valid_i) begin
                  r_dvd   <= w_xabs;
                  r_dsr   <= w_yabs;
                  r_xraw  <= bus.X_i;
                  r_qneg  <= bus.div_signed_i & (bus.X_i[DW-1] ^ bus.Y_i[DW-1]);
                  r_rneg  <= bus.div_signed_i & bus.X_i[DW-1];
                  r_div0  <= (bus.Y_i == '0);
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_rem <= w_rem_nx;
               r_dvd <= w_dvd_nx;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) begin
                  r_q     <= w_qfix;
                  r_r     <= w_rfix;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.ready_i) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
